video_fx_stream_wrap: RTL and testbench

//  Avalon-ST wrapper around the fixed-latency, non-stallable video effects pipeline.
//  - Accepts camera pixels on a sink with a valid/ready handshake and forwards them to the effects input.
//  - Delays valid/sop/eop tags by the pipeline latency and re-joins them with the processed pixel.
//  - Buffers the result in a FIFO and drives an Avalon-ST source.
//  - Uses credit-based back-pressure so that no in-flight pixel is ever lost.

---
 rtl/video_fx_stream_wrap.sv | 185 ++++++++++++++++++
 tb/tb_video_fx_stream_wrap.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/video_fx_stream_wrap.sv
// Avalon-ST shell around a fixed-latency, non-stallable video effects pipeline, with a show-ahead output FIFO.
// Latency: accept to src_valid is FX_LATENCY+1 cycles when the FIFO is empty; FIFO push to src_valid is 1 cycle.
// Backpressure: snk_ready is withheld once buffered plus in-flight pixels reach DEPTH, so the pipeline never stalls.
//
// Ports (video_fx_stream_wrap):
//   clk, reset_n                       clock, asynchronous active-low reset
//   snk_data/valid/sop/eop, snk_ready  Avalon-ST sink (camera pixels, RGB565)
//   fx_pixel_out, fx_pixel_in          to / from the effects pipeline
//   src_data/valid/sop/eop, src_ready  Avalon-ST source (processed pixels)
//   fifo_level                         entries held in the output FIFO
//   overflow_err                       sticky, a FIFO write arrived while full

// Generic show-ahead FIFO; the head entry is visible on rd_dat while rd_vld is high.
// Latency: a push is visible on rd_* the next cycle (no bypass).
// Backpressure: a push while full without a pop is dropped and flagged on wr_drop.
module vfx_fifo #(
  parameter int W     = 18,
  parameter int DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_vld,
  input  logic [W-1:0]                 wr_dat,
  output logic                         wr_drop,
  input  logic                         rd_rdy,
  output logic                         rd_vld,
  output logic [W-1:0]                 rd_dat,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic [$clog2(DEPTH+1)-1:0]   level_nxt
);
  localparam int LW = $clog2(DEPTH+1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          empty, full, push, pop;

  assign empty   = (level_q == '0);
  assign full    = (level_q == LW'(DEPTH));
  assign pop     = rd_rdy & ~empty;
  // A simultaneous pop frees the slot, so a push at full is still legal then.
  assign push    = wr_vld & (~full | pop);
  assign wr_drop = wr_vld & full & ~pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    // Pointers wrap explicitly so DEPTH need not be a power of two.
    if (push) wr_ptr_d = (wr_ptr_q == PW'(DEPTH-1)) ? '0 : wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = (rd_ptr_q == PW'(DEPTH-1)) ? '0 : rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage carries no reset; stale contents are masked while empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_dat;
  end

  assign rd_vld    = ~empty;
  assign rd_dat    = empty ? '0 : mem_q[rd_ptr_q];
  assign level     = level_q;
  assign level_nxt = level_d;
endmodule

module video_fx_stream_wrap #(
  parameter int FX_LATENCY = 6,
  parameter int DEPTH      = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [15:0]                snk_data,
  input  logic                       snk_valid,
  input  logic                       snk_sop,
  input  logic                       snk_eop,
  output logic                       snk_ready,
  output logic [15:0]                fx_pixel_out,
  input  logic [15:0]                fx_pixel_in,
  output logic [15:0]                src_data,
  output logic                       src_valid,
  output logic                       src_sop,
  output logic                       src_eop,
  input  logic                       src_ready,
  output logic [$clog2(DEPTH+1)-1:0] fifo_level,
  output logic                       overflow_err
);
  localparam int LW = $clog2(DEPTH+1);

  logic [FX_LATENCY-1:0] tag_v_q, tag_v_d;
  logic [FX_LATENCY-1:0] tag_sop_q, tag_sop_d;
  logic [FX_LATENCY-1:0] tag_eop_q, tag_eop_d;
  logic [LW-1:0]         inflight_q, inflight_d;
  logic                  snk_ready_q, snk_ready_d;
  logic                  overflow_q, overflow_d;
  logic                  accept, tag_exit, wr_drop;
  logic [LW-1:0]         level, level_nxt;
  logic [17:0]           head_dat;

  assign fx_pixel_out = snk_data;
  assign accept       = snk_valid & snk_ready_q;
  assign tag_exit     = tag_v_q[FX_LATENCY-1];

  always_comb begin
    tag_v_d      = '0;
    tag_sop_d    = '0;
    tag_eop_d    = '0;
    tag_v_d[0]   = accept;
    tag_sop_d[0] = snk_sop;
    tag_eop_d[0] = snk_eop;
    for (int i = 1; i < FX_LATENCY; i++) begin
      tag_v_d[i]   = tag_v_q[i-1];
      tag_sop_d[i] = tag_sop_q[i-1];
      tag_eop_d[i] = tag_eop_q[i-1];
    end

    inflight_d = inflight_q;
    case ({accept, tag_exit})
      2'b10:   inflight_d = inflight_q + LW'(1);
      2'b01:   inflight_d = inflight_q - LW'(1);
      default: inflight_d = inflight_q;
    endcase

    // Registered credit check on next-state counts: same value as decoding the
    // current registers next cycle, but held low through reset.
    snk_ready_d = (({1'b0, level_nxt} + {1'b0, inflight_d}) < (LW+1)'(DEPTH));
    overflow_d  = overflow_q | wr_drop;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tag_v_q     <= '0;
      tag_sop_q   <= '0;
      tag_eop_q   <= '0;
      inflight_q  <= '0;
      snk_ready_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      tag_v_q     <= tag_v_d;
      tag_sop_q   <= tag_sop_d;
      tag_eop_q   <= tag_eop_d;
      inflight_q  <= inflight_d;
      snk_ready_q <= snk_ready_d;
      overflow_q  <= overflow_d;
    end
  end

  // The processed pixel lines up with the tag leaving the last stage.
  vfx_fifo #(.W(18), .DEPTH(DEPTH)) u_out_fifo (
    .clk       (clk),
    .rst_n     (reset_n),
    .wr_vld    (tag_exit),
    .wr_dat    ({tag_sop_q[FX_LATENCY-1], tag_eop_q[FX_LATENCY-1], fx_pixel_in}),
    .wr_drop   (wr_drop),
    .rd_rdy    (src_ready),
    .rd_vld    (src_valid),
    .rd_dat    (head_dat),
    .level     (level),
    .level_nxt (level_nxt)
  );

  assign src_sop      = head_dat[17];
  assign src_eop      = head_dat[16];
  assign src_data     = head_dat[15:0];
  assign snk_ready    = snk_ready_q;
  assign fifo_level   = level;
  assign overflow_err = overflow_q;
endmodule

// File: tb/tb_video_fx_stream_wrap.sv
`timescale 1ns/1ps
module tb_video_fx_stream_wrap;
  localparam int FXL   = 6;
  localparam int DEPTH = 16;
  localparam int LW    = $clog2(DEPTH+1);

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [15:0]   snk_data = 16'h0;
  logic          snk_valid = 1'b0, snk_sop = 1'b0, snk_eop = 1'b0;
  logic          snk_ready;
  logic [15:0]   fx_pixel_out, fx_pixel_in;
  logic [15:0]   src_data;
  logic          src_valid, src_sop, src_eop;
  logic          src_ready = 1'b0;
  logic [LW-1:0] fifo_level;
  logic          overflow_err;

  int checks = 0, errors = 0, out_cnt = 0;
  logic [17:0] exp_q[$];
  logic last_acc;

  always #5 clk = ~clk;

  video_fx_stream_wrap #(.FX_LATENCY(FXL), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n),
    .snk_data(snk_data), .snk_valid(snk_valid), .snk_sop(snk_sop), .snk_eop(snk_eop),
    .snk_ready(snk_ready),
    .fx_pixel_out(fx_pixel_out), .fx_pixel_in(fx_pixel_in),
    .src_data(src_data), .src_valid(src_valid), .src_sop(src_sop), .src_eop(src_eop),
    .src_ready(src_ready),
    .fifo_level(fifo_level), .overflow_err(overflow_err)
  );

  // Effects pipeline model: inverts the pixel, FXL cycles after sampling it.
  logic [15:0] fx_pipe [FXL];
  always @(posedge clk) begin
    fx_pipe[0] <= ~fx_pixel_out;
    for (int i = 1; i < FXL; i++) fx_pipe[i] <= fx_pipe[i-1];
  end
  assign fx_pixel_in = fx_pipe[FXL-1];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Output scoreboard: every pop must match the oldest accepted pixel.
  always @(negedge clk) begin
    logic [17:0] e;
    if (reset_n && src_valid && src_ready) begin
      out_cnt++;
      check("out_pending", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("out_dat", {14'd0, src_sop, src_eop, src_data}, {14'd0, e});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a sink beat for the coming edge; record it if it will be accepted.
  task automatic drive(input logic v, input logic [15:0] d, input logic s, input logic e);
    snk_valid = v;
    snk_data  = d;
    snk_sop   = s;
    snk_eop   = e;
    last_acc  = v & snk_ready;
    if (last_acc) exp_q.push_back({s, e, ~d});
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || src_valid) && n < 200) begin
      step();
      n++;
    end
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int base, nrdy, acc_cnt, max_lvl;

    // Reset state
    snk_data = 16'hABCD;
    repeat (3) @(posedge clk);
    #1;
    check("rst_src_valid", 32'(src_valid), 32'd0);
    check("rst_snk_ready", 32'(snk_ready), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_ovf", 32'(overflow_err), 32'd0);
    check("rst_src_data", {14'd0, src_sop, src_eop, src_data}, 32'd0);
    check("rst_fx_out", 32'(fx_pixel_out), 32'hABCD);
    reset_n = 1'b1;
    step();
    check("rel_snk_ready", 32'(snk_ready), 32'd1);

    // 1: single pixel, src_valid exactly FXL+1 cycles after accept
    src_ready = 1'b1;
    drive(1'b1, 16'hF800, 1'b1, 1'b1);
    check("t1_accept", 32'(last_acc), 32'd1);
    for (int k = 1; k <= 7; k++) begin
      step();
      if (k == 1) drive(1'b0, 16'h0, 1'b0, 1'b0);
      check($sformatf("t1_valid_k%0d", k), 32'(src_valid), 32'(k == 7));
      if (k == 7) check("t1_head", {14'd0, src_sop, src_eop, src_data}, 32'h3_07FF);
    end
    wait_drain("t1_drain");

    // 2: 100 back-to-back pixels with src_ready high
    base = out_cnt;
    nrdy = 0;
    for (int i = 0; i < 100; i++) begin
      drive(1'b1, 16'(i * 37 + 5), i == 0, i == 99);
      if (!last_acc) nrdy++;
      if (i == 50) check("t2_level_steady", 32'(fifo_level), 32'd1);
      step();
    end
    drive(1'b0, 16'h0, 1'b0, 1'b0);
    check("t2_ready_held", 32'(nrdy), 32'd0);
    wait_drain("t2_drain");
    check("t2_count", 32'(out_cnt - base), 32'd100);

    // 3: back-pressure, exactly DEPTH accepts then stall
    src_ready = 1'b0;
    acc_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      drive(1'b1, 16'(16'h1000 + i), i == 0, i == 15);
      if (last_acc) acc_cnt++;
      step();
    end
    check("t3_accepts", 32'(acc_cnt), 32'd16);
    check("t3_snk_ready", 32'(snk_ready), 32'd0);
    check("t3_level", 32'(fifo_level), 32'd16);
    check("t3_ovf", 32'(overflow_err), 32'd0);
    check("t3_head_held", {14'd0, src_sop, src_eop, src_data}, 32'h2_EFFF);
    drive(1'b0, 16'h0, 1'b0, 1'b0);
    base = out_cnt;
    src_ready = 1'b1;
    wait_drain("t3_drain");
    check("t3_count", 32'(out_cnt - base), 32'd16);
    check("t3_level_empty", 32'(fifo_level), 32'd0);

    // 4: valid pattern 1,0,0,1 gives exactly two writes
    src_ready = 1'b0;
    drive(1'b1, 16'h0A0A, 1'b1, 1'b0); step();
    drive(1'b0, 16'h1111, 1'b0, 1'b0); step();
    drive(1'b0, 16'h2222, 1'b0, 1'b0); step();
    drive(1'b1, 16'h0B0B, 1'b0, 1'b1); step();
    drive(1'b0, 16'h0, 1'b0, 1'b0);
    repeat (10) step();
    check("t4_level", 32'(fifo_level), 32'd2);
    check("t4_head", {14'd0, src_sop, src_eop, src_data}, 32'h2_F5F5);
    src_ready = 1'b1;
    wait_drain("t4_drain");

    // 5: full FIFO, then continuous push/pop through the credit loop
    src_ready = 1'b0;
    for (int i = 0; i < 25; i++) begin
      drive(1'b1, 16'(16'h2000 + i), 1'b0, 1'b0);
      step();
    end
    check("t5_full_level", 32'(fifo_level), 32'd16);
    check("t5_full_ready", 32'(snk_ready), 32'd0);
    src_ready = 1'b1;
    max_lvl = 0;
    for (int j = 0; j < 40; j++) begin
      drive(1'b1, 16'(16'h3000 + j), 1'b0, 1'b0);
      if (int'(fifo_level) > max_lvl) max_lvl = int'(fifo_level);
      if (j == 20) begin
        check("t5_steady_level", 32'(fifo_level), 32'd9);
        check("t5_steady_ready", 32'(snk_ready), 32'd1);
      end
      step();
    end
    drive(1'b0, 16'h0, 1'b0, 1'b0);
    check("t5_max_level", 32'(max_lvl), 32'd16);
    wait_drain("t5_drain");
    check("t5_ovf", 32'(overflow_err), 32'd0);

    // 6: reset mid-frame with 10 pixels in flight
    src_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 16'(16'h4000 + i), i == 0, 1'b0);
      step();
    end
    check("t6_pre_level", 32'(fifo_level), 32'd4);
    check("t6_pre_valid", 32'(src_valid), 32'd1);
    reset_n = 1'b0;
    drive(1'b0, 16'h0, 1'b0, 1'b0);
    exp_q.delete();
    #1;
    check("t6_rst_valid", 32'(src_valid), 32'd0);
    check("t6_rst_level", 32'(fifo_level), 32'd0);
    check("t6_rst_ready", 32'(snk_ready), 32'd0);
    step();
    reset_n = 1'b1;
    step();
    check("t6_rel_ready", 32'(snk_ready), 32'd1);
    check("t6_rel_ovf", 32'(overflow_err), 32'd0);
    base = out_cnt;
    src_ready = 1'b1;
    repeat (15) step();
    check("t6_no_output", 32'(out_cnt - base), 32'd0);
    check("t6_valid_low", 32'(src_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
